// File: rtl/fifo_pkg.sv
// Shared helpers for the token-ring FIFO: count width, reset token pattern
// and the one-hot check applied to both token rings.
package fifo_pkg;

    // Widest token ring that onehot_ok() can check.
    localparam int MAX_CELLS = 1024;

    // After reset (or a resync), every token ring holds a single bit at cell 0.
    localparam logic [0:0] TOK_RESET = 1'b1;

    function automatic int cw(input int n);
        return $clog2(n + 1);
    endfunction

    // Callers zero-extend their ring to MAX_CELLS. The extra zero bits do not
    // change whether exactly one bit is set.
    function automatic logic onehot_ok(input logic [MAX_CELLS-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_CELLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/fifo_token_ring.sv
// One-hot token ring: rotates one cell per advance, reloads cell 0 on resync,
// and reports combinationally when the ring is not one-hot.
module fifo_token_ring
    import fifo_pkg::*;
#(
    parameter int N_CELLS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               resync,
    output logic [N_CELLS-1:0] tok,
    output logic               bad
);

    localparam logic [N_CELLS-1:0] TOK_INIT = N_CELLS'(TOK_RESET);

    logic [N_CELLS-1:0] tok_d, tok_q;

    // NOTE: tok_d gets its default value first, so no path through this block leaves it unassigned. That keeps synthesis from inferring a latch.
    always_comb begin
        tok_d = tok_q;
        if (resync)
            tok_d = TOK_INIT;
        else if (advance)
            tok_d = {tok_q[N_CELLS-2:0], tok_q[N_CELLS-1]};
    end

    // NOTE: state uses non-blocking assignments. Every flop then samples values from before the clock edge, whatever order the processes run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tok_q <= TOK_INIT;
        else
            tok_q <= tok_d;
    end

    assign tok = tok_q;
    assign bad = ~onehot_ok(MAX_CELLS'(tok_q));

endmodule

// File: rtl/token_ring_fifo.sv
// Single-clock FIFO with one-hot put/get token rings, occupancy flags, sticky errors
// and ring-corruption flush. Define TOKEN_RING_FIFO_FWFT_EN for first-word-fall-through reads.
module token_ring_fifo
    import fifo_pkg::*;
#(
    parameter  int N_BITS   = 32,
    parameter  int N_CELLS  = 16,
    parameter  int AF_LEVEL = N_CELLS - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CW       = cw(N_CELLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_put,
    input  logic [N_BITS-1:0] data_put,
    input  logic              req_get,
    output logic [N_BITS-1:0] data_get,
    output logic              valid_get,
    output logic              full_out,
    output logic              empty_out,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              ovf_err,
    output logic              udf_err,
    output logic              tok_err
);

    logic [N_CELLS-1:0] put_tok, get_tok;
    logic               put_bad, get_bad;
    logic               put_ok, get_ok;
    logic [N_BITS-1:0]  mem [N_CELLS];
    logic [N_BITS-1:0]  rd_word;
    logic [CW-1:0]      count_d, count_q;
    logic               ovf_d, ovf_q, udf_d, udf_q;

    fifo_token_ring #(.N_CELLS(N_CELLS)) u_put_ring (
        .clk(clk), .reset(reset), .advance(put_ok), .resync(tok_err),
        .tok(put_tok), .bad(put_bad)
    );

    fifo_token_ring #(.N_CELLS(N_CELLS)) u_get_ring (
        .clk(clk), .reset(reset), .advance(get_ok), .resync(tok_err),
        .tok(get_tok), .bad(get_bad)
    );

    assign tok_err      = put_bad | get_bad;
    assign full_out     = (int'(count_q) == N_CELLS);
    assign empty_out    = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign count        = count_q;
    assign ovf_err      = ovf_q;
    assign udf_err      = udf_q;

    // A corrupt ring cycle discards all requests and leaves the error flags untouched.
    always_comb begin
        put_ok  = req_put & ~full_out & ~tok_err;
        get_ok  = req_get & ~empty_out & ~tok_err;
        ovf_d   = ovf_q | (req_put & full_out & ~tok_err);
        udf_d   = udf_q | (req_get & empty_out & ~tok_err);
        count_d = tok_err ? '0 : count_q + CW'(put_ok) - CW'(get_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: the storage array has no reset. A clear is never needed because the token rings and count define which words are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CELLS; i++)
            if (put_ok && put_tok[i])
                mem[i] <= data_put;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_CELLS; i++)
            rd_word = rd_word | (mem[i] & {N_BITS{get_tok[i]}});
    end

`ifdef TOKEN_RING_FIFO_FWFT_EN
    // Zero is shown while empty, so data_get matches its reset value.
    assign data_get  = empty_out ? '0 : rd_word;
    assign valid_get = ~empty_out;
`else
    logic [N_BITS-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (get_ok) begin
            data_d  = rd_word;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_get  = data_q;
    assign valid_get = valid_q;
`endif

endmodule
